// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, one bit per clock, LSB first.
// Results (y/cout/ovf) update only on entry to DONE and hold until the next completion.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic [CW-1:0]    count;
  logic             carry, msb_cin;
  logic             s, c_next, accept, last;

  always_comb begin
    s          = op_a[0] ^ op_b[0] ^ carry;
    c_next     = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    accept     = start && (state != RUN);
    last       = (count == CW'(WIDTH - 1));
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      count   <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      y       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      // Subtraction as a + ~b + 1: invert B and seed the carry with sub.
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= sub;
      count <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      acc   <= {s, acc[WIDTH-1:1]};
      carry <= c_next;
      count <= count + 1'b1;
      if (count == CW'(WIDTH - 2)) msb_cin <= c_next;
      if (last) begin
        y    <= {s, acc[WIDTH-1:1]};
        cout <= c_next;
        ovf  <= msb_cin ^ c_next;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub (WIDTH=8) against an arithmetic reference model.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] y;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_y;
  logic       prev_c, prev_v;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {cout, ovf, y} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] z, input logic s);
    int unsigned full;
    int          sx, sz, sres;
    logic        c, v;
    sx = int'($signed(x));
    sz = int'($signed(z));
    if (!s) begin
      full = int'(x) + int'(z);
      sres = sx + sz;
    end else begin
      full = int'(x) + 256 - int'(z);
      sres = sx - sz;
    end
    c = (full >= 256);
    v = (sres > 127) || (sres < -128);
    return {c, v, 8'(full)};
  endfunction

  task automatic chk_hold(input string tag);
    chk({tag, "_y"}, 32'(y), 32'(prev_y));
    chk({tag, "_cout"}, 32'(cout), 32'(prev_c));
    chk({tag, "_ovf"}, 32'(ovf), 32'(prev_v));
  endtask

  task automatic chk_result(input string tag, input logic [7:0] x, input logic [7:0] z, input logic s);
    logic [9:0] m;
    m = model(x, z, s);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'(m[7:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(m[9]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m[8]));
    prev_y = m[7:0];
    prev_c = m[9];
    prev_v = m[8];
  endtask

  // One operation from IDLE; optional re-pulse of start mid-RUN with other operands.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] z,
                        input logic s, input bit glitch);
    a = x; b = z; sub = s; start = 1'b1;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    chk({tag, "_done0"}, 32'(done), 32'd0);
    chk_hold({tag, "_hold0"});
    for (int c = 1; c < 8; c++) begin
      start = (glitch && c == 3);
      if (glitch && c == 3) begin
        a = ~x; b = ~z; sub = ~s;
      end
      tick();
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
    end
    start = 1'b0;
    chk_hold({tag, "_hold"});
    tick();
    chk_result(tag, x, z, s);
    tick();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk_hold({tag, "_after"});
  endtask

  logic [7:0] oa [3];
  logic [7:0] ob [3];
  logic       os [3];

  initial begin
    prev_y = '0; prev_c = 1'b0; prev_v = 1'b0;
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 8'hFF; b = 8'h01;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_hold("rst");
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_norun", 32'(busy), 32'd0);

    run_op("add", 8'd23, 8'd42, 1'b0, 1'b0);
    run_op("addwrap", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("addovf", 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("sub", 8'd10, 8'd3, 1'b1, 1'b0);
    run_op("subneg", 8'd3, 8'd10, 1'b1, 1'b0);
    run_op("subovf", 8'h80, 8'h01, 1'b1, 1'b0);
    run_op("ignore", 8'd100, 8'd27, 1'b0, 1'b1);

    // Back-to-back: start held high through DONE.
    for (int i = 0; i < 3; i++) begin
      oa[i] = 8'($urandom); ob[i] = 8'($urandom); os[i] = 1'($urandom);
    end
    a = oa[0]; b = ob[0]; sub = os[0]; start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        a = oa[i+1]; b = ob[i+1]; sub = os[i+1];
      end else begin
        start = 1'b0;
      end
      for (int c = 1; c < 8; c++) begin
        tick();
        chk("b2b_busy", 32'(busy), 32'd1);
        chk_hold("b2b_hold");
      end
      tick();
      chk_result("b2b", oa[i], ob[i], os[i]);
      if (i < 2) begin
        tick();
        chk("b2b_restart", 32'(busy), 32'd1);
        chk("b2b_pulse", 32'(done), 32'd0);
        chk_hold("b2b_rhold");
      end
    end
    tick();
    chk("b2b_end_busy", 32'(busy), 32'd0);
    chk("b2b_end_done", 32'(done), 32'd0);

    // Reset mid-operation.
    a = 8'd55; b = 8'd66; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_y = '0; prev_c = 1'b0; prev_v = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk_hold("mrst");
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("mrst_nodone", 32'(done), 32'd0);
    end
    run_op("post_rst", 8'd200, 8'd100, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++)
      run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
